// File: rtl/rt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rt_pkg
//  Purpose  : Shared types and constants for the RT-Core issue stage.
//             RT_XLEN / RT_RADDR_W size the datapath and register addresses,
//             rt_fwd_src_e names the operand source, rt_issue_t is the payload
//             of the issue register (micro-op carried separately because its
//             width is a module parameter).
//  Revision : 1.0 - initial release
// ============================================================================
package rt_pkg;

  localparam int RT_XLEN    = 32;
  localparam int RT_RADDR_W = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } rt_fwd_src_e;

  typedef struct packed {
    logic [RT_XLEN-1:0]    rs1_val;
    logic [RT_XLEN-1:0]    rs2_val;
    logic [RT_RADDR_W-1:0] rd;
    logic                  rd_we;
    logic [RT_XLEN-1:0]    imm;
  } rt_issue_t;

endpackage
`default_nettype wire

// File: rtl/rt_operand_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : rt_operand_fwd
//  Purpose  : Resolves one source operand. Priority EX (data ready) > MEM >
//             WB > register file. Raises hazard_o when EX holds the register
//             but its data is not yet available (load-use).
//  Ports    : rs_i/en_i        source address and read enable
//             rf_data_i        register file read data
//             ex_*_i           EX-stage forwarding source
//             mem_*_i          MEM-stage forwarding source
//             wb_*_i           register file write port (same-cycle bypass)
//             val_o            resolved operand
//             hazard_o         load-use hazard on this operand
//  Revision : 1.0 - initial release
// ============================================================================
module rt_operand_fwd
  import rt_pkg::*;
(
  input  logic [RT_RADDR_W-1:0] rs_i,
  input  logic                  en_i,
  input  logic [RT_XLEN-1:0]    rf_data_i,
  input  logic                  ex_valid_i,
  input  logic [RT_RADDR_W-1:0] ex_rd_i,
  input  logic                  ex_data_ok_i,
  input  logic [RT_XLEN-1:0]    ex_data_i,
  input  logic                  mem_valid_i,
  input  logic [RT_RADDR_W-1:0] mem_rd_i,
  input  logic [RT_XLEN-1:0]    mem_data_i,
  input  logic                  wb_we_i,
  input  logic [RT_RADDR_W-1:0] wb_waddr_i,
  input  logic [RT_XLEN-1:0]    wb_wdata_i,
  output logic [RT_XLEN-1:0]    val_o,
  output logic                  hazard_o
);

  rt_fwd_src_e src;
  logic        ex_hit;
  logic        mem_hit;
  logic        wb_hit;

  assign ex_hit  = ex_valid_i  && (ex_rd_i    == rs_i);
  assign mem_hit = mem_valid_i && (mem_rd_i   == rs_i);
  assign wb_hit  = wb_we_i     && (wb_waddr_i == rs_i);

  always_comb begin
    src      = FWD_RF;
    hazard_o = 1'b0;
    if (en_i) begin
      // A pending EX load falls through to MEM/WB; the value is irrelevant
      // because the hazard blocks the accept.
      if (ex_hit && ex_data_ok_i) begin
        src = FWD_EX;
      end else if (mem_hit) begin
        src = FWD_MEM;
      end else if (wb_hit) begin
        src = FWD_WB;
      end
      hazard_o = ex_hit && !ex_data_ok_i;
    end
  end

  always_comb begin
    val_o = rf_data_i;
    case (src)
      FWD_EX:  val_o = ex_data_i;
      FWD_MEM: val_o = mem_data_i;
      FWD_WB:  val_o = wb_wdata_i;
      default: val_o = rf_data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rt_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : rt_issue_stage
//  Purpose  : Decode-to-execute issue stage. Drives register file read ports,
//             forwards from EX/MEM/WB, stalls on load-use hazards and holds
//             the issued instruction in a valid/ready register toward EX.
//  Ports    : clk, rst_n (async, active-low), flush
//             dec_*            decode-side handshake and instruction fields
//             rf_raddr*/rf_rdata*   register file read ports
//             ex_fwd_*, mem_fwd_*, wb_*  forwarding sources
//             iss_*            issue register toward EX (valid/ready)
//             stall_cnt        saturating count of load-use stall cycles
//  Revision : 1.0 - initial release
// ============================================================================
module rt_issue_stage
  import rt_pkg::*;
#(
  parameter int UOP_W       = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [RT_RADDR_W-1:0]  dec_rs1,
  input  logic [RT_RADDR_W-1:0]  dec_rs2,
  input  logic                   dec_rs1_en,
  input  logic                   dec_rs2_en,
  input  logic [RT_RADDR_W-1:0]  dec_rd,
  input  logic                   dec_rd_we,
  input  logic [UOP_W-1:0]       dec_uop,
  input  logic [RT_XLEN-1:0]     dec_imm,
  output logic [RT_RADDR_W-1:0]  rf_raddr1,
  output logic [RT_RADDR_W-1:0]  rf_raddr2,
  input  logic [RT_XLEN-1:0]     rf_rdata1,
  input  logic [RT_XLEN-1:0]     rf_rdata2,
  input  logic                   ex_fwd_valid,
  input  logic [RT_RADDR_W-1:0]  ex_fwd_rd,
  input  logic                   ex_fwd_data_ok,
  input  logic [RT_XLEN-1:0]     ex_fwd_data,
  input  logic                   mem_fwd_valid,
  input  logic [RT_RADDR_W-1:0]  mem_fwd_rd,
  input  logic [RT_XLEN-1:0]     mem_fwd_data,
  input  logic                   wb_we,
  input  logic [RT_RADDR_W-1:0]  wb_waddr,
  input  logic [RT_XLEN-1:0]     wb_wdata,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [RT_XLEN-1:0]     iss_rs1_val,
  output logic [RT_XLEN-1:0]     iss_rs2_val,
  output logic [RT_RADDR_W-1:0]  iss_rd,
  output logic                   iss_rd_we,
  output logic [UOP_W-1:0]       iss_uop,
  output logic [RT_XLEN-1:0]     iss_imm,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [RT_XLEN-1:0]     op1_val;
  logic [RT_XLEN-1:0]     op2_val;
  logic                   op1_haz;
  logic                   op2_haz;
  logic                   hazard;
  logic                   slot_free;
  logic                   accept;

  logic                   iss_valid_q, iss_valid_d;
  rt_issue_t              iss_q, iss_d;
  logic [UOP_W-1:0]       uop_q, uop_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  rt_operand_fwd u_fwd_rs1 (
    .rs_i        (dec_rs1),
    .en_i        (dec_rs1_en),
    .rf_data_i   (rf_rdata1),
    .ex_valid_i  (ex_fwd_valid),
    .ex_rd_i     (ex_fwd_rd),
    .ex_data_ok_i(ex_fwd_data_ok),
    .ex_data_i   (ex_fwd_data),
    .mem_valid_i (mem_fwd_valid),
    .mem_rd_i    (mem_fwd_rd),
    .mem_data_i  (mem_fwd_data),
    .wb_we_i     (wb_we),
    .wb_waddr_i  (wb_waddr),
    .wb_wdata_i  (wb_wdata),
    .val_o       (op1_val),
    .hazard_o    (op1_haz)
  );

  rt_operand_fwd u_fwd_rs2 (
    .rs_i        (dec_rs2),
    .en_i        (dec_rs2_en),
    .rf_data_i   (rf_rdata2),
    .ex_valid_i  (ex_fwd_valid),
    .ex_rd_i     (ex_fwd_rd),
    .ex_data_ok_i(ex_fwd_data_ok),
    .ex_data_i   (ex_fwd_data),
    .mem_valid_i (mem_fwd_valid),
    .mem_rd_i    (mem_fwd_rd),
    .mem_data_i  (mem_fwd_data),
    .wb_we_i     (wb_we),
    .wb_waddr_i  (wb_waddr),
    .wb_wdata_i  (wb_wdata),
    .val_o       (op2_val),
    .hazard_o    (op2_haz)
  );

  assign hazard    = dec_valid && (op1_haz || op2_haz);
  assign slot_free = !iss_valid_q || iss_ready;
  // rst_n gates ready so decode never hands off while the stage is in reset.
  assign dec_ready = rst_n && !flush && !hazard && slot_free;
  assign accept    = dec_valid && dec_ready;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    uop_d       = uop_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d   = 1'b1;
      iss_d.rs1_val = op1_val;
      iss_d.rs2_val = op2_val;
      iss_d.rd      = dec_rd;
      iss_d.rd_we   = dec_rd_we;
      iss_d.imm     = dec_imm;
      uop_d         = dec_uop;
    end else if (slot_free) begin
      iss_valid_d = 1'b0;
    end

    if (hazard && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      uop_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      uop_q       <= uop_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_rs1_val = iss_q.rs1_val;
  assign iss_rs2_val = iss_q.rs2_val;
  assign iss_rd      = iss_q.rd;
  assign iss_rd_we   = iss_q.rd_we;
  assign iss_uop     = uop_q;
  assign iss_imm     = iss_q.imm;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rt_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rt_issue_stage
//  Purpose  : Self-checking bench for rt_issue_stage: table of single-cycle
//             vectors plus hand sequences for backpressure, flush, reset and
//             stall counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rt_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_en, dec_rs2_en, dec_rd_we;
  logic [7:0]  dec_uop;
  logic [31:0] dec_imm;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_fwd_valid, ex_fwd_data_ok;
  logic [2:0]  ex_fwd_rd;
  logic [31:0] ex_fwd_data;
  logic        mem_fwd_valid;
  logic [2:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_we;
  logic [2:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_rs1_val, iss_rs2_val, iss_imm;
  logic [2:0]  iss_rd;
  logic        iss_rd_we;
  logic [7:0]  iss_uop;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rt_issue_stage #(.UOP_W(8), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_uop(dec_uop), .dec_imm(dec_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd),
    .ex_fwd_data_ok(ex_fwd_data_ok), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
    .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_uop(iss_uop), .iss_imm(iss_imm),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    string       name;
    logic        flush, dec_valid;
    logic [2:0]  rs1, rs2;
    logic        rs1_en, rs2_en;
    logic [2:0]  rd;
    logic        rd_we;
    logic [7:0]  uop;
    logic [31:0] imm, rf1, rf2;
    logic        exv, exok;
    logic [2:0]  exrd;
    logic [31:0] exd;
    logic        memv;
    logic [2:0]  memrd;
    logic [31:0] memd;
    logic        wbwe;
    logic [2:0]  wba;
    logic [31:0] wbd;
    logic        e_rdy, e_valid;
    logic [31:0] e_rs1, e_rs2;
    logic [15:0] e_stall;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t base(input string name);
    vec_t v;
    v.name = name; v.flush = 0; v.dec_valid = 1;
    v.rs1 = 0; v.rs2 = 0; v.rs1_en = 1; v.rs2_en = 0;
    v.rd = 0; v.rd_we = 0; v.uop = 0; v.imm = 0; v.rf1 = 0; v.rf2 = 0;
    v.exv = 0; v.exok = 1; v.exrd = 0; v.exd = 0;
    v.memv = 0; v.memrd = 0; v.memd = 0;
    v.wbwe = 0; v.wba = 0; v.wbd = 0;
    v.e_rdy = 1; v.e_valid = 1; v.e_rs1 = 0; v.e_rs2 = 0; v.e_stall = 0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    flush = v.flush; dec_valid = v.dec_valid;
    dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rs1_en = v.rs1_en; dec_rs2_en = v.rs2_en;
    dec_rd = v.rd; dec_rd_we = v.rd_we; dec_uop = v.uop; dec_imm = v.imm;
    rf_rdata1 = v.rf1; rf_rdata2 = v.rf2;
    ex_fwd_valid = v.exv; ex_fwd_data_ok = v.exok; ex_fwd_rd = v.exrd; ex_fwd_data = v.exd;
    mem_fwd_valid = v.memv; mem_fwd_rd = v.memrd; mem_fwd_data = v.memd;
    wb_we = v.wbwe; wb_waddr = v.wba; wb_wdata = v.wbd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst_n = 0; iss_ready = 1;
    v = base("idle"); v.dec_valid = 0; v.rs1_en = 0;
    apply(v);

    // Table: each vector is one decode cycle with EX always ready.
    vecs[0] = base("r0_mem_fwd");
    vecs[0].rs1 = 0; vecs[0].memv = 1; vecs[0].memrd = 0; vecs[0].memd = 32'h0000_00AA;
    vecs[0].e_rs1 = 32'h0000_00AA;

    vecs[1] = base("wb_bypass");
    vecs[1].rs1 = 3; vecs[1].rf1 = 0; vecs[1].wbwe = 1; vecs[1].wba = 3; vecs[1].wbd = 32'h1234_5678;
    vecs[1].e_rs1 = 32'h1234_5678;

    vecs[2] = base("prio_ex");
    vecs[2].rs1 = 5; vecs[2].rs2 = 5; vecs[2].rs2_en = 1;
    vecs[2].exv = 1; vecs[2].exrd = 5; vecs[2].exd = 1;
    vecs[2].memv = 1; vecs[2].memrd = 5; vecs[2].memd = 2;
    vecs[2].wbwe = 1; vecs[2].wba = 5; vecs[2].wbd = 3;
    vecs[2].e_rs1 = 1; vecs[2].e_rs2 = 1;

    vecs[3] = vecs[2]; vecs[3].name = "load_use";
    vecs[3].exok = 0; vecs[3].e_rdy = 0; vecs[3].e_valid = 0; vecs[3].e_stall = 1;

    vecs[4] = base("ex_to_mem");
    vecs[4].rs1 = 5; vecs[4].rs2 = 5; vecs[4].rs2_en = 1;
    vecs[4].memv = 1; vecs[4].memrd = 5; vecs[4].memd = 1;
    vecs[4].e_rs1 = 1; vecs[4].e_rs2 = 1; vecs[4].e_stall = 1;

    vecs[5] = base("rs2_disabled");
    vecs[5].rs1 = 1; vecs[5].rf1 = 32'h55; vecs[5].rs2 = 6; vecs[5].rf2 = 32'hDEAD;
    vecs[5].exv = 1; vecs[5].exrd = 6; vecs[5].exok = 0;
    vecs[5].e_rs1 = 32'h55; vecs[5].e_rs2 = 32'hDEAD; vecs[5].e_stall = 1;

    vecs[6] = base("mem_over_wb");
    vecs[6].rs1 = 2; vecs[6].rs2 = 2; vecs[6].rs2_en = 1; vecs[6].rf2 = 9;
    vecs[6].memv = 1; vecs[6].memrd = 2; vecs[6].memd = 32'h22;
    vecs[6].wbwe = 1; vecs[6].wba = 2; vecs[6].wbd = 32'h33;
    vecs[6].e_rs1 = 32'h22; vecs[6].e_rs2 = 32'h22; vecs[6].e_stall = 1;

    vecs[7] = base("rf_no_match");
    vecs[7].rs1 = 4; vecs[7].rf1 = 32'h44; vecs[7].rs2 = 4; vecs[7].rs2_en = 1; vecs[7].rf2 = 32'h45;
    vecs[7].exv = 1; vecs[7].exrd = 2; vecs[7].exd = 32'hEE;
    vecs[7].memv = 1; vecs[7].memrd = 3; vecs[7].memd = 32'h77;
    vecs[7].wbwe = 1; vecs[7].wba = 5; vecs[7].wbd = 32'h99;
    vecs[7].e_rs1 = 32'h44; vecs[7].e_rs2 = 32'h45; vecs[7].e_stall = 1;

    vecs[8] = base("idle_decode");
    vecs[8].dec_valid = 0; vecs[8].e_valid = 0; vecs[8].e_stall = 1;

    vecs[9] = base("hazard_needs_valid");
    vecs[9].dec_valid = 0; vecs[9].rs1 = 7; vecs[9].exv = 1; vecs[9].exrd = 7; vecs[9].exok = 0;
    vecs[9].e_valid = 0; vecs[9].e_stall = 1;

    vecs[10] = base("flush_with_hazard");
    vecs[10].flush = 1; vecs[10].rs1 = 7; vecs[10].exv = 1; vecs[10].exrd = 7; vecs[10].exok = 0;
    vecs[10].e_rdy = 0; vecs[10].e_valid = 0; vecs[10].e_stall = 1;

    for (int i = 0; i < NV; i++) begin
      vecs[i].rd    = 3'(i);
      vecs[i].rd_we = i[0];
      vecs[i].uop   = 8'h10 + 8'(i);
      vecs[i].imm   = 32'hA000_0000 + 32'(i);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_iss_valid", {31'd0, iss_valid}, 0);
    chk("reset_dec_ready", {31'd0, dec_ready}, 0);
    chk("reset_rs1", iss_rs1_val, 0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, ".dec_ready"}, {31'd0, dec_ready}, {31'd0, vecs[i].e_rdy});
      chk({vecs[i].name, ".rf_raddr1"}, {29'd0, rf_raddr1}, {29'd0, vecs[i].rs1});
      tick();
      chk({vecs[i].name, ".iss_valid"}, {31'd0, iss_valid}, {31'd0, vecs[i].e_valid});
      chk({vecs[i].name, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, vecs[i].e_stall});
      if (vecs[i].e_valid) begin
        chk({vecs[i].name, ".rs1_val"}, iss_rs1_val, vecs[i].e_rs1);
        chk({vecs[i].name, ".rs2_val"}, iss_rs2_val, vecs[i].e_rs2);
        chk({vecs[i].name, ".rd"}, {29'd0, iss_rd}, {29'd0, vecs[i].rd});
        chk({vecs[i].name, ".rd_we"}, {31'd0, iss_rd_we}, {31'd0, vecs[i].rd_we});
        chk({vecs[i].name, ".uop"}, {24'd0, iss_uop}, {24'd0, vecs[i].uop});
        chk({vecs[i].name, ".imm"}, iss_imm, vecs[i].imm);
      end
    end

    // Backpressure: instruction A issued, then EX stalls for 3 cycles.
    v = base("A"); v.rs1 = 1; v.rf1 = 32'hA1A1; v.rf2 = 32'hB2; v.rd = 7; v.rd_we = 1;
    v.uop = 8'hAA; v.imm = 32'h1111;
    apply(v); iss_ready = 1;
    tick();
    chk("bp_A_valid", {31'd0, iss_valid}, 1);
    chk("bp_A_rs1", iss_rs1_val, 32'hA1A1);
    v.rf1 = 32'hB1B1; v.uop = 8'hBB; v.imm = 32'h2222; v.rd = 2; v.rd_we = 0;
    apply(v); iss_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_dec_ready", {31'd0, dec_ready}, 0);
      tick();
      chk("bp_hold_valid", {31'd0, iss_valid}, 1);
      chk("bp_hold_rs1", iss_rs1_val, 32'hA1A1);
      chk("bp_hold_rs2", iss_rs2_val, 32'hB2);
      chk("bp_hold_rd", {29'd0, iss_rd}, 7);
      chk("bp_hold_rd_we", {31'd0, iss_rd_we}, 1);
      chk("bp_hold_uop", {24'd0, iss_uop}, 32'hAA);
      chk("bp_hold_imm", iss_imm, 32'h1111);
    end
    iss_ready = 1;
    @(negedge clk);
    chk("bp_release_dec_ready", {31'd0, dec_ready}, 1);
    tick();
    chk("bp_B_valid", {31'd0, iss_valid}, 1);
    chk("bp_B_rs1", iss_rs1_val, 32'hB1B1);
    chk("bp_B_uop", {24'd0, iss_uop}, 32'hBB);

    // Flush while EX is stalled; decode holds C through the flush cycle.
    v.rf1 = 32'hC1C1; v.uop = 8'hCC; v.imm = 32'h3333;
    apply(v); iss_ready = 0; flush = 1;
    @(negedge clk);
    chk("flush_dec_ready", {31'd0, dec_ready}, 0);
    tick();
    chk("flush_iss_valid", {31'd0, iss_valid}, 0);
    flush = 0; iss_ready = 1;
    @(negedge clk);
    chk("post_flush_dec_ready", {31'd0, dec_ready}, 1);
    tick();
    chk("post_flush_valid", {31'd0, iss_valid}, 1);
    chk("post_flush_rs1", iss_rs1_val, 32'hC1C1);

    // Asynchronous reset mid-cycle discards the held instruction.
    iss_ready = 0;
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", {31'd0, iss_valid}, 0);
    chk("async_rst_rs1", iss_rs1_val, 0);
    chk("async_rst_rs2", iss_rs2_val, 0);
    chk("async_rst_rd", {29'd0, iss_rd}, 0);
    chk("async_rst_rd_we", {31'd0, iss_rd_we}, 0);
    chk("async_rst_uop", {24'd0, iss_uop}, 0);
    chk("async_rst_imm", iss_imm, 0);
    chk("async_rst_stall", {16'd0, stall_cnt}, 0);
    chk("async_rst_dec_ready", {31'd0, dec_ready}, 0);
    @(negedge clk);
    rst_n = 1;

    // Saturation: permanent load-use hazard.
    v = base("sat"); v.rs1 = 5; v.exv = 1; v.exrd = 5; v.exok = 0;
    apply(v); iss_ready = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    tick();
    chk("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    chk("sat_no_issue", {31'd0, iss_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
